// File: rtl/apb_master_queue.sv
// APB4 master engine: queued read/write commands run through SETUP/ACCESS phases,
// with a single-entry response slot carrying read data, PSLVERR and timeout status.
module apb_master_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16,
  parameter int PROT_EN    = 1,
  parameter int STRB_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]       cmd_strb,
  input  logic [2:0]                    cmd_prot,
  output logic [$clog2(CMD_DEPTH):0]    cmd_count,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_write,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  output logic [2:0]                    pprot,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } cmd_t;

  cmd_t                  fifo_q [CMD_DEPTH];
  cmd_t                  head;
  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic                  rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic                  push, issue;

  assign cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // The slot may be refilled only if it is empty or being drained this very cycle.
  assign issue     = (state_q == S_IDLE) && (count_q != '0) && (!rsp_valid_q || rsp_ready);
  assign head      = fifo_q[rd_ptr_q];

  // NOTE: storage carries no reset; occupancy and pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
  end

  // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q && !rsp_ready;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_write_d   = rsp_write_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case ({push, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          wait_d    = '0;
          paddr_d   = head.addr;
          pwrite_d  = head.write;
          pwdata_d  = head.write ? head.wdata : '0;
          pstrb_d   = !head.write ? '0 : ((STRB_EN != 0) ? head.strb : '1);
          pprot_d   = (PROT_EN != 0) ? head.prot : 3'b000;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = pwrite_q;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_write_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_write_q   <= rsp_write_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_count   = count_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
